// File: rtl/race_pkg.sv
// Shared types, screen geometry and the clamped axis-step helper for race_ctl.
package race_pkg;

  // Screen and sprite geometry; legal car positions derive from these.
  localparam int unsigned SCREEN_W    = 1024;
  localparam int unsigned SCREEN_H    = 768;
  localparam int unsigned SPRITE_SIZE = 128;

  // Datapath widths.
  localparam int unsigned POS_W  = 11;
  localparam int unsigned CALC_W = 12;
  localparam int unsigned TIME_W = 12;
  localparam int unsigned CD_W   = 2;
  localparam int unsigned ST_W   = 2;

  // Button vector layout used by the synchronizer bank.
  localparam int unsigned NUM_BTNS  = 5;
  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RIGHT = 2;
  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_DOWN  = 4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_FINISH    = 2'd3
  } race_state_e;

  // One frame of movement on one axis: decrement saturates at 0, increment at lim,
  // both-or-neither holds. Computed at CALC_W bits so pos+step cannot wrap.
  function automatic logic [CALC_W-1:0] step_axis(
    input logic [CALC_W-1:0] pos,
    input logic              dec,
    input logic              inc,
    input logic [CALC_W-1:0] step,
    input logic [CALC_W-1:0] lim
  );
    logic [CALC_W-1:0] res;
    logic [CALC_W-1:0] sum;
    res = pos;
    sum = pos + step;
    if (dec && !inc) begin
      res = (pos < step) ? '0 : (pos - step);
    end else if (inc && !dec) begin
      res = (sum > lim) ? lim : sum;
    end
    return res;
  endfunction

endpackage

// File: rtl/race_ctl_if.sv
// Frame timing, button inputs and layer/sprite outputs of the race controller.
interface race_ctl_if;
  import race_pkg::*;

  logic              vblnk;
  logic              btn_start;
  logic              btn_left;
  logic              btn_right;
  logic              btn_up;
  logic              btn_down;
  logic              bg_visible;
  logic              track_visible;
  logic              player_visible;
  logic [POS_W-1:0]  xpos;
  logic [POS_W-1:0]  ypos;
  logic [CD_W-1:0]   countdown;
  logic [TIME_W-1:0] race_time;
  logic [ST_W-1:0]   state;

  // Controller side.
  modport slave (
    input  vblnk, btn_start, btn_left, btn_right, btn_up, btn_down,
    output bg_visible, track_visible, player_visible,
    output xpos, ypos, countdown, race_time, state
  );

  // Timing generator / button side.
  modport master (
    output vblnk, btn_start, btn_left, btn_right, btn_up, btn_down,
    input  bg_visible, track_visible, player_visible,
    input  xpos, ypos, countdown, race_time, state
  );

endinterface

// File: rtl/btn_sync.sv
// 2-FF synchronizer bank with a one-clock rising-edge pulse per bit.
module btn_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // Two synchronizer stages followed by the edge-detect history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_c  = sync_q & ~prev_q;

endmodule

// File: rtl/race_ctl.sv
// Per-frame race flow FSM: layer enables, countdown digit, race timer, car position.
module race_ctl
  import race_pkg::*;
#(
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned RACE_FRAMES  = 3600,
  parameter int unsigned STEP         = 4,
  parameter int unsigned START_X      = 448,
  parameter int unsigned START_Y      = 600,
  parameter int unsigned X_MAX        = SCREEN_W - SPRITE_SIZE,
  parameter int unsigned Y_MAX        = SCREEN_H - SPRITE_SIZE
) (
  input logic       pclk,
  input logic       rst,
  race_ctl_if.slave bus
);

  localparam int unsigned CNT_W = (COUNT_FRAMES > 1) ? $clog2(COUNT_FRAMES) : 1;

  race_state_e       state_q,     state_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CD_W-1:0]   countdown_q, countdown_d;
  logic [TIME_W-1:0] race_time_q, race_time_d;
  logic [POS_W-1:0]  xpos_q,      xpos_d;
  logic [POS_W-1:0]  ypos_q,      ypos_d;
  logic              bg_q,        bg_d;
  logic              track_q,     track_d;
  logic              player_q,    player_d;
  logic              vblnk_prev_q;

  logic [NUM_BTNS-1:0] btn_lvl;
  logic [NUM_BTNS-1:0] btn_rise;
  logic                start_edge_c;
  logic                tick_c;
  logic [CALC_W-1:0]   x_step_c;
  logic [CALC_W-1:0]   y_step_c;
  logic                unused_btn;

  btn_sync #(
    .WIDTH (NUM_BTNS)
  ) u_btn_sync (
    .clk     (pclk),
    .rst_n   (rst),
    .btn_i   ({bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left, bus.btn_start}),
    .level_o (btn_lvl),
    .rise_c  (btn_rise)
  );

  // Only the start button is edge-driven; only the steering buttons are level-driven.
  assign unused_btn   = ^{btn_lvl[BTN_START], btn_rise[NUM_BTNS-1:1]};
  assign start_edge_c = btn_rise[BTN_START];
  assign tick_c       = bus.vblnk & ~vblnk_prev_q;

  // Candidate positions for this frame, clamped to the legal window.
  always_comb begin
    x_step_c = step_axis(CALC_W'(xpos_q), btn_lvl[BTN_LEFT], btn_lvl[BTN_RIGHT],
                         CALC_W'(STEP), CALC_W'(X_MAX));
    y_step_c = step_axis(CALC_W'(ypos_q), btn_lvl[BTN_UP], btn_lvl[BTN_DOWN],
                         CALC_W'(STEP), CALC_W'(Y_MAX));
  end

  // Frame-start detector history.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_prev_q <= 1'b0;
    end else begin
      vblnk_prev_q <= bus.vblnk;
    end
  end

  // State and output registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      countdown_q <= '0;
      race_time_q <= '0;
      xpos_q      <= POS_W'(START_X);
      ypos_q      <= POS_W'(START_Y);
      bg_q        <= 1'b1;
      track_q     <= 1'b0;
      player_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      countdown_q <= countdown_d;
      race_time_q <= race_time_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      bg_q        <= bg_d;
      track_q     <= track_d;
      player_q    <= player_d;
    end
  end

  // Next-state and next-output logic; start edges act immediately, the rest waits for tick.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    countdown_d = countdown_q;
    race_time_d = race_time_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          state_d     = ST_COUNTDOWN;
          countdown_d = CD_W'(3);
          frame_cnt_d = '0;
          xpos_d      = POS_W'(START_X);
          ypos_d      = POS_W'(START_Y);
          race_time_d = '0;
        end
      end

      ST_COUNTDOWN: begin
        if (tick_c) begin
          if (frame_cnt_q == CNT_W'(COUNT_FRAMES - 1)) begin
            frame_cnt_d = '0;
            if (countdown_q == CD_W'(1)) begin
              state_d     = ST_RACE;
              countdown_d = '0;
            end else begin
              countdown_d = countdown_q - CD_W'(1);
            end
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RACE: begin
        if (start_edge_c) begin
          // Abort wins over a coincident tick: no move, timer holds.
          state_d = ST_FINISH;
        end else if (tick_c) begin
          xpos_d      = POS_W'(x_step_c);
          ypos_d      = POS_W'(y_step_c);
          race_time_d = race_time_q + TIME_W'(1);
          if (race_time_q == TIME_W'(RACE_FRAMES - 1)) begin
            state_d = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        if (start_edge_c) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Layer enables follow the state being entered so they register alongside it.
    bg_d     = 1'b1;
    track_d  = (state_d != ST_IDLE);
    player_d = (state_d != ST_IDLE);
  end

  assign bus.bg_visible     = bg_q;
  assign bus.track_visible  = track_q;
  assign bus.player_visible = player_q;
  assign bus.xpos           = xpos_q;
  assign bus.ypos           = ypos_q;
  assign bus.countdown      = countdown_q;
  assign bus.race_time      = race_time_q;
  assign bus.state          = state_q;

endmodule

// File: doc/race_ctl.md
# race_ctl

Game-flow controller for the racer display pipeline. Runs the race state machine (title → countdown → race → finish) once per video frame and drives the three layer-enable inputs of the background, track and car draw stages. Also produces the player car's sprite position. Sits on the 65 MHz pixel clock beside the XGA timing generator and replaces the fixed layer sequencing used so far.

## Interface
Parameters:
- `COUNT_FRAMES`, 60: frames per countdown digit.
- `RACE_FRAMES`, 3600: race length in frames (60 s at 60 Hz).
- `STEP`, 4: pixels moved per frame per axis.
- `START_X`, 448: car x on countdown entry.
- `START_Y`, 600: car y on countdown entry.
- `X_MAX`, 896: largest legal car x (1024 − 128).
- `Y_MAX`, 640: largest legal car y (768 − 128).

Ports:
- `pclk  in  1`: pixel clock. One clock; reset is asynchronous and active-low.
- `rst  in  1`: asynchronous, active-low reset.
- `vblnk  in  1`: vertical blank from the timing generator, registered.
- `btn_start, btn_left, btn_right, btn_up, btn_down  in  1 each`: debounced asynchronous buttons, active-high.
- `bg_visible, track_visible, player_visible  out  1 each`: layer enables.
- `xpos, ypos  out  11`: car top-left position.
- `countdown  out  2`: digit shown (3..1); 0 outside the countdown.
- `race_time  out  12`: frames elapsed in the race.
- `state  out  2`: current state, for debug.

## Operation
- Each button passes through a 2-FF synchronizer. `start_edge` = synced start high and its previous value low (one pclk).
- `tick` = `vblnk` high and `vblnk_d` low (rising edge, one pclk per frame).
- All state and position updates happen only on `tick`, except the start-edge transitions.

States:
- **IDLE**: bg=1, track=0, player=0.
  - `start_edge` → COUNTDOWN with countdown=3, frame_cnt=0, xpos=START_X, ypos=START_Y, race_time=0.
- **COUNTDOWN**: all layers 1; car frozen.
  - On each tick, frame_cnt++.
  - At frame_cnt==COUNT_FRAMES−1: frame_cnt=0 and countdown−−.
  - If countdown was 1 at that point → RACE with countdown=0.
  - `start_edge` is ignored.
- **RACE**: all layers 1.
  - On each tick, x and y are updated independently:
    - left only: x = (x < STEP) ? 0 : x−STEP.
    - right only: x = min(x+STEP, X_MAX).
    - both or neither pressed: x holds. y follows the same rules with up/down and Y_MAX.
  - race_time++ on each tick.
  - On the tick where race_time==RACE_FRAMES−1 → FINISH, with race_time reaching RACE_FRAMES.
  - `start_edge` → FINISH immediately (abort); race_time holds.
- **FINISH**: all layers 1; car and race_time frozen.
  - `start_edge` → IDLE. xpos/ypos hold until the next countdown entry.

Arithmetic and boundaries:
- Clamp arithmetic uses 12 bits internally, so x+STEP never wraps.
- Positions are never outside 0..X_MAX / 0..Y_MAX.
- race_time never exceeds RACE_FRAMES.
- A `start_edge` coinciding with a tick in RACE gives FINISH; no move is applied that tick.
- A `start_edge` coinciding with the final RACE tick gives FINISH.

## Timing
- Reset values: state=IDLE, bg_visible=1, track_visible=0, player_visible=0, xpos=START_X, ypos=START_Y, countdown=0, race_time=0; synchronizers and `vblnk_d` cleared.
- Reset mid-race returns to these values immediately (asynchronously); no pending tick survives.
- All outputs are registered.
- Tick-driven updates appear one pclk after the first edge at which `vblnk` is sampled high. They are therefore stable for the whole blank interval, before the next active line.
- Button-to-effect latency: 2 pclk for synchronization, then the next tick.
- Start transitions occur 3 pclk after the `btn_start` rise (2 sync + 1 edge register).
- A start press held across frames produces exactly one transition.

## Structure
- Package `race_pkg` holds:
  - the state enum: IDLE=0, COUNTDOWN=1, RACE=2, FINISH=3.
  - the screen constants 1024/768 and sprite size 128, from which X_MAX and Y_MAX defaults are derived.
- One sub-module, `btn_sync`: 2-FF synchronizer plus rising-edge pulse, parameterized by width. It is instantiated once for the five buttons.
- The FSM, frame counter and position clamp live in `race_ctl`.

## Test plan
- Reset, then 5 frames with no input → state=0, bg=1, track=0, player=0, xpos=448, ypos=600, race_time=0.
- Start pulse in IDLE → state=1, countdown=3 after 3 pclk. With COUNT_FRAMES=2: countdown 3→2→1 on every second tick, then state=2 with countdown=0 after 6 ticks.
- RACE, left held 200 frames from x=448 → x reaches 0 after 112 ticks and stays 0. Right held from x=894 → 896, then holds.
- RACE, left+right held together with up held → x unchanged, y decreases by 4 per tick.
- RACE_FRAMES=10 → FINISH on the 10th tick with race_time=10. Further ticks leave race_time and position frozen; start → IDLE.
- Reset asserted mid-RACE at x=100, then released → all outputs at reset values. A start pulse arriving 1 pclk after release is still taken after sync.
